// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_master_bridge_if                                         |
// | Description : Command/response handshake plus APB4 requester bus for the   |
// |               apb_master_bridge.                                           |
// |   master modport (bridge view):                                            |
// |     in : cmd_valid cmd_write cmd_addr cmd_wdata cmd_strb                   |
// |          pready prdata pslverr                                             |
// |     out: cmd_ready rsp_valid rsp_rdata rsp_err rsp_timeout                 |
// |          psel penable pwrite paddr pwdata pstrb                            |
// |   slave modport: the same signals seen from the host/completer side.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface apb_master_bridge_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   // host command / response
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_strb;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   // APB4 requester side
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [STRB_W-1:0] pstrb;
   logic              pready;
   logic [DATA_W-1:0] prdata;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_master_bridge                                            |
// | Description : APB4 requester. Turns single-beat host commands into         |
// |               SETUP/ACCESS transfers, honours wait states, reports         |
// |               pslverr and aborts a hung ACCESS phase after TIMEOUT_CYCLES. |
// |   pclk    : APB clock                                                      |
// |   presetn : asynchronous active-low reset                                  |
// |   bus     : apb_master_bridge_if.master (cmd/rsp handshake + APB bus)      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module apb_master_bridge #(
   parameter int ADDR_W         = 12,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input wire pclk,
   input wire presetn,
   apb_master_bridge_if.master bus
);
   localparam int STRB_W = DATA_W / 8;
   // Width guarded so TIMEOUT_CYCLES=0 (timeout disabled) still elaborates.
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] TO_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [STRB_W-1:0] pstrb_q, pstrb_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              w_timeout_hit;

   // Last allowed wait cycle: a pready=0 here ends ACCESS after exactly
   // TIMEOUT_CYCLES cycles.
   assign w_timeout_hit = TO_EN && (cnt_q == TO_LAST);

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               state_d   = ST_SETUP;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = bus.cmd_write;
               paddr_d   = bus.cmd_addr;
               // Reads never expose stale write data or strobes on the bus.
               pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
               pstrb_d   = bus.cmd_write ? bus.cmd_strb  : '0;
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         ST_ACCESS: begin
            if (bus.pready) begin
               // pready wins even on the abort cycle.
               state_d       = ST_IDLE;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
               rsp_err_d     = bus.pslverr;
               rsp_timeout_d = 1'b0;
            end else if (w_timeout_hit) begin
               state_d       = ST_IDLE;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end else if (TO_EN) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q       <= ST_IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus.cmd_ready   = (state_q == ST_IDLE);
   assign bus.psel        = psel_q;
   assign bus.penable     = penable_q;
   assign bus.pwrite      = pwrite_q;
   assign bus.paddr       = paddr_q;
   assign bus.pwdata      = pwdata_q;
   assign bus.pstrb       = pstrb_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_master_bridge                                         |
// | Description : Randomized self-checking bench for apb_master_bridge. A      |
// |               transaction-level timeline model predicts every cycle of     |
// |               psel/penable/cmd_ready/rsp_valid and the response fields.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_apb_master_bridge;
   localparam int T       = 16;
   localparam int N       = 60;
   localparam int RST_IDX = 30;

   typedef struct {
      bit          write;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;   // pready=0 cycles before pready=1 in ACCESS
      logic [31:0] rdata;
      bit          err;
      int          gap;     // idle cycles before presenting this command
   } txn_t;

   logic pclk = 1'b0;
   logic presetn;
   always #5 pclk = ~pclk;

   apb_master_bridge_if #(.ADDR_W(12), .DATA_W(32)) bus ();

   apb_master_bridge #(
      .ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(T)
   ) dut (
      .pclk(pclk), .presetn(presetn), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   txn_t txns[N];
   // model of the transfer currently on the bus
   txn_t cur;
   bit   have = 0;
   int   cur_idx = 0;
   int   t_acc = 0;     // accept edge: SETUP is cycle t_acc
   int   t_len = 0;     // number of ACCESS cycles
   int   cyc = 0;       // cycle n = interval following posedge n
   int   next_idx = 0;
   int   gap_left = 0;
   // observations stored for the literal pins
   int          acc_edge[N];
   int          lat[N];
   int          pen[N];
   logic [31:0] obs_rdata[N];
   logic        obs_err[N];
   logic        obs_to[N];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   function automatic bit mdl_ready(input int c);
      return !(have && c >= t_acc && c <= t_acc + t_len);
   endfunction

   task automatic present(input int i);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = txns[i].write;
      bus.cmd_addr  = txns[i].addr;
      bus.cmd_wdata = txns[i].wdata;
      bus.cmd_strb  = txns[i].strb;
   endtask

   task automatic drive_cmd(input bit acc_now);
      if (!presetn) begin
         bus.cmd_valid = 1'b0;
      end else if (bus.cmd_valid && !acc_now) begin
         // held stable until accepted
      end else begin
         if (acc_now) gap_left = (next_idx < N) ? txns[next_idx].gap : 0;
         if (next_idx < N && gap_left == 0) begin
            present(next_idx);
         end else begin
            bus.cmd_valid = 1'b0;
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr  = 12'($urandom);
            bus.cmd_wdata = $urandom;
            bus.cmd_strb  = 4'($urandom);
            if (gap_left > 0) gap_left--;
         end
      end
   endtask

   task automatic drive_completer();
      if (have && cyc >= t_acc + 1 && cyc <= t_acc + t_len &&
          (cyc - (t_acc + 1)) == cur.waits) begin
         bus.pready  = 1'b1;
         bus.prdata  = cur.rdata;
         bus.pslverr = cur.err;
      end else begin
         // pready must stay low in ACCESS before the chosen cycle; elsewhere don't-care
         bus.pready  = (have && cyc >= t_acc + 1 && cyc <= t_acc + t_len) ? 1'b0 : 1'($urandom);
         bus.prdata  = $urandom;
         bus.pslverr = 1'($urandom);
      end
   endtask

   task automatic step();
      bit acc_now;
      @(posedge pclk);
      cyc++;
      acc_now = 1'b0;
      if (presetn && bus.cmd_valid && mdl_ready(cyc - 1)) begin
         cur      = txns[next_idx];
         cur_idx  = next_idx;
         have     = 1'b1;
         t_acc    = cyc;
         t_len    = (cur.waits < T) ? cur.waits + 1 : T;
         acc_edge[next_idx] = cyc;
         next_idx++;
         acc_now  = 1'b1;
      end
      #1;
      drive_cmd(acc_now);
      drive_completer();
   endtask

   // per-cycle compare against the timeline model
   int pen_cnt = 0;
   always @(negedge pclk) begin : compare
      bit          in_txn;
      bit          to;
      logic [31:0] e_rdata;
      in_txn = have && cyc >= t_acc && cyc <= t_acc + t_len;
      if (have && cyc == t_acc) pen_cnt = 0;
      if (bus.penable === 1'b1) pen_cnt++;
      chk("psel", {63'd0, bus.psel}, {63'd0, in_txn});
      chk("penable", {63'd0, bus.penable}, {63'd0, in_txn && cyc >= t_acc + 1});
      chk("cmd_ready", {63'd0, bus.cmd_ready}, {63'd0, !in_txn});
      if (in_txn) begin
         chk("paddr", {52'd0, bus.paddr}, {52'd0, cur.addr});
         chk("pwrite", {63'd0, bus.pwrite}, {63'd0, cur.write});
         chk("pwdata", {32'd0, bus.pwdata}, {32'd0, cur.write ? cur.wdata : 32'd0});
         chk("pstrb", {60'd0, bus.pstrb}, {60'd0, cur.write ? cur.strb : 4'd0});
      end
      if (have && cyc == t_acc + t_len + 1) begin
         to      = (cur.waits >= T);
         e_rdata = (to || cur.write) ? 32'd0 : cur.rdata;
         chk("rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
         chk("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, e_rdata});
         chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, to ? 1'b1 : cur.err});
         chk("rsp_timeout", {63'd0, bus.rsp_timeout}, {63'd0, to});
         lat[cur_idx]       = cyc - t_acc;
         pen[cur_idx]       = pen_cnt;
         obs_rdata[cur_idx] = bus.rsp_rdata;
         obs_err[cur_idx]   = bus.rsp_err;
         obs_to[cur_idx]    = bus.rsp_timeout;
      end else begin
         chk("rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      end
   end

   initial begin
      int guard;
      // directed head of the stream
      txns[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 0};
      txns[1] = '{1'b0, 12'h020, 32'h0, 4'h0, 3, 32'h12345678, 1'b0, 0};
      txns[2] = '{1'b1, 12'h030, 32'hCAFEF00D, 4'h5, 1, 32'h0, 1'b1, 1};
      txns[3] = '{1'b0, 12'h040, 32'h0, 4'h0, 20, 32'h55AA55AA, 1'b0, 0};
      txns[4] = '{1'b0, 12'h050, 32'h0, 4'h0, T - 1, 32'h0BADF00D, 1'b1, 0};
      for (int i = 5; i < N; i++) begin
         int r;
         r = int'($urandom_range(99, 0));
         txns[i].write = 1'($urandom);
         txns[i].addr  = 12'($urandom);
         txns[i].wdata = $urandom;
         txns[i].strb  = 4'($urandom);
         txns[i].waits = (r < 60) ? int'($urandom_range(3, 0)) :
                         (r < 85) ? int'($urandom_range(14, 4)) : int'($urandom_range(20, 15));
         txns[i].rdata = $urandom;
         txns[i].err   = ($urandom_range(3, 0) == 0);
         txns[i].gap   = ($urandom_range(2, 0) == 0) ? int'($urandom_range(3, 0)) : 0;
      end
      txns[RST_IDX].waits = 10;
      txns[RST_IDX + 1]   = '{1'b0, 12'h0A0, 32'h0, 4'h0, 2, 32'hA5A50F0F, 1'b0, 0};
      for (int i = 0; i < N; i++) lat[i] = -1;

      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
      bus.cmd_wdata = '0;   bus.cmd_strb  = '0;
      bus.pready    = 1'b0; bus.prdata    = '0;   bus.pslverr = 1'b0;
      presetn = 1'b1;
      #1 presetn = 1'b0;

      step(); step();
      #3;
      chk("rst_paddr", {52'd0, bus.paddr}, 64'd0);
      chk("rst_pwdata", {32'd0, bus.pwdata}, 64'd0);
      chk("rst_pstrb", {60'd0, bus.pstrb}, 64'd0);
      chk("rst_pwrite", {63'd0, bus.pwrite}, 64'd0);
      chk("rst_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
      chk("rst_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
      chk("rst_rsp_timeout", {63'd0, bus.rsp_timeout}, 64'd0);
      presetn = 1'b1;

      guard = 0;
      while (!(next_idx == N && !have) && !(next_idx == N && cyc > t_acc + t_len + 2)
             && guard < 20000) begin
         step();
         guard++;
         if (have && cur_idx == RST_IDX && cyc == t_acc + 3 && presetn) begin
            #1 presetn = 1'b0;
            #1;
            chk("async_rst_psel", {63'd0, bus.psel}, 64'd0);
            chk("async_rst_penable", {63'd0, bus.penable}, 64'd0);
            chk("async_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
            chk("async_rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
            have = 1'b0;
            bus.cmd_valid = 1'b0;
            step(); step();
            presetn = 1'b1;
         end
      end
      chk("cycle_budget", {63'd0, guard < 20000}, 64'd1);
      repeat (2) @(posedge pclk);

      // literal pins on the model's timing arithmetic
      chk("t1_latency", 64'(lat[0]), 64'd2);
      chk("t1_penable_cycles", 64'(pen[0]), 64'd1);
      chk("t5_psel_low_gap", 64'(acc_edge[1] - (acc_edge[0] + lat[0])), 64'd1);
      chk("t2_latency", 64'(lat[1]), 64'd5);
      chk("t2_penable_cycles", 64'(pen[1]), 64'd4);
      chk("t2_rdata", {32'd0, obs_rdata[1]}, 64'h12345678);
      chk("t3_err", {63'd0, obs_err[2]}, 64'd1);
      chk("t3_timeout", {63'd0, obs_to[2]}, 64'd0);
      chk("t4_latency", 64'(lat[3]), 64'd17);
      chk("t4_penable_cycles", 64'(pen[3]), 64'd16);
      chk("t4_err", {63'd0, obs_err[3]}, 64'd1);
      chk("t4_timeout", {63'd0, obs_to[3]}, 64'd1);
      chk("t4_rdata", {32'd0, obs_rdata[3]}, 64'd0);
      chk("abort_edge_pready_latency", 64'(lat[4]), 64'd17);
      chk("abort_edge_pready_timeout", {63'd0, obs_to[4]}, 64'd0);
      chk("t6_no_rsp_for_reset_txn", 64'(lat[RST_IDX]), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t6_post_reset_latency", 64'(lat[RST_IDX + 1]), 64'd4);
      chk("t6_post_reset_rdata", {32'd0, obs_rdata[RST_IDX + 1]}, 64'hA5A50F0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
